// File: rtl/uart_mmio.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_mmio : memory-mapped 8N1 UART, TX FSM plus RX FSM with holding store |
// | Option   : define UART_RX_FIFO_EN for a 4-entry RX FIFO instead of 1 byte |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_mmio #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic        WEUART,
  input  logic        REUART,
  input  logic [7:0]  DataIn,
  output logic [31:0] DataOut,
  input  logic        serial_in,
  output logic        serial_out
);

  localparam int SYMBOL = CLOCK_FREQ / BAUD_RATE;
  localparam int CW     = (SYMBOL < 2) ? 1 : $clog2(SYMBOL);
  localparam logic [CW-1:0] c_sym_last  = CW'(SYMBOL - 1);
  localparam logic [CW-1:0] c_half_last = CW'((SYMBOL / 2 > 0) ? (SYMBOL / 2 - 1) : 0);
  localparam logic [31:0] c_addr_status = 32'h8000_0000;
  localparam logic [31:0] c_addr_txstat = 32'h8000_0004;
  localparam logic [31:0] c_addr_tx     = 32'h8000_0008;
  localparam logic [31:0] c_addr_rx     = 32'h8000_000C;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          tx_state_q, rx_state_q;
  logic [CW-1:0]   tx_cnt_q, rx_cnt_q;
  logic [2:0]      tx_bit_q, rx_bit_q;
  logic [7:0]      tx_shift_q, rx_shift_q;
  logic            serial_out_q;
  logic            w_tx_wr, w_rd, w_rx_done, w_pop, w_push_ok;
  logic            tx_ready, rx_valid, overrun;
  logic [7:0]      rx_head;

  assign w_tx_wr    = WEUART && (Address == c_addr_tx);
  assign w_rd       = REUART && (Address == c_addr_rx);
  assign tx_ready   = (tx_state_q == S_IDLE);
  assign serial_out = serial_out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q   <= S_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      serial_out_q <= 1'b1;
    end else begin
      case (tx_state_q)
        S_IDLE: if (w_tx_wr) begin
          tx_shift_q   <= DataIn;
          tx_cnt_q     <= '0;
          serial_out_q <= 1'b0;
          tx_state_q   <= S_START;
        end
        S_START: if (tx_cnt_q == c_sym_last) begin
          tx_cnt_q     <= '0;
          tx_bit_q     <= '0;
          serial_out_q <= tx_shift_q[0];
          tx_shift_q   <= {1'b0, tx_shift_q[7:1]};
          tx_state_q   <= S_DATA;
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
        S_DATA: if (tx_cnt_q == c_sym_last) begin
          tx_cnt_q <= '0;
          if (tx_bit_q == 3'd7) begin
            serial_out_q <= 1'b1;
            tx_state_q   <= S_STOP;
          end else begin
            serial_out_q <= tx_shift_q[0];
            tx_shift_q   <= {1'b0, tx_shift_q[7:1]};
            tx_bit_q     <= tx_bit_q + 1'b1;
          end
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
        S_STOP: if (tx_cnt_q == c_sym_last) begin
          tx_cnt_q   <= '0;
          tx_state_q <= S_IDLE;
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  // Start bit is re-checked at half a symbol; later samples fall mid-bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      case (rx_state_q)
        S_IDLE: if (!serial_in) begin
          rx_cnt_q   <= '0;
          rx_state_q <= S_START;
        end
        S_START: if (rx_cnt_q == c_half_last) begin
          rx_cnt_q   <= '0;
          rx_bit_q   <= '0;
          rx_state_q <= serial_in ? S_IDLE : S_DATA;
        end else rx_cnt_q <= rx_cnt_q + 1'b1;
        S_DATA: if (rx_cnt_q == c_sym_last) begin
          rx_cnt_q   <= '0;
          rx_shift_q <= {serial_in, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
          else                  rx_bit_q   <= rx_bit_q + 1'b1;
        end else rx_cnt_q <= rx_cnt_q + 1'b1;
        S_STOP: if (rx_cnt_q == c_sym_last) begin
          rx_cnt_q   <= '0;
          rx_state_q <= S_IDLE;
        end else rx_cnt_q <= rx_cnt_q + 1'b1;
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  assign w_rx_done = (rx_state_q == S_STOP) && (rx_cnt_q == c_sym_last) && serial_in;

`ifdef UART_RX_FIFO_EN
  logic [7:0] fifo_q [4];
  logic [1:0] rd_q, wr_q;
  logic [2:0] count_q, count_d;
  logic       overrun_q;

  assign w_pop     = w_rd && (count_q != 3'd0);
  assign w_push_ok = w_rx_done && ((count_q != 3'd4) || w_pop);
  assign count_d   = count_q - {2'b0, w_pop} + {2'b0, w_push_ok};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (w_pop) begin
        rd_q      <= rd_q + 1'b1;
        overrun_q <= 1'b0;
      end
      if (w_push_ok) begin
        fifo_q[wr_q] <= rx_shift_q;
        wr_q         <= wr_q + 1'b1;
      end else if (w_rx_done) overrun_q <= 1'b1;
    end
  end

  assign rx_valid = (count_q != 3'd0);
  assign overrun  = overrun_q;
  assign rx_head  = fifo_q[rd_q];
`else
  logic [7:0] hold_q;
  logic       valid_q, overrun_q;

  assign w_pop     = w_rd && valid_q;
  assign w_push_ok = w_rx_done && (!valid_q || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (w_pop) begin
        hold_q    <= '0;
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
      if (w_push_ok) begin
        hold_q  <= rx_shift_q;
        valid_q <= 1'b1;
      end else if (w_rx_done) overrun_q <= 1'b1;
    end
  end

  assign rx_valid = valid_q;
  assign overrun  = overrun_q;
  assign rx_head  = hold_q;
`endif

  always_comb begin
    DataOut = 32'h0;
    case (Address)
      c_addr_status: DataOut = {30'b0, overrun, rx_valid};
      c_addr_txstat: DataOut = {31'b0, tx_ready};
      c_addr_rx:     DataOut = {24'b0, (rx_valid ? rx_head : 8'h00)};
      default:       DataOut = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/uart_mmio.md
UART_MMIO -- requirements
Module: uart_mmio

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50_000_000, clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, serial bit rate in bit/s.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Address  input  32  CPU data address for the current access.
REQ-006 SHALL have port WEUART  input  1  TX write strobe, qualified by Address 0x80000008.
REQ-007 SHALL have port REUART  input  1  RX read-and-pop strobe, qualified by Address 0x8000000C.
REQ-008 SHALL have port DataIn  input  8  TX byte, sampled when a TX write is accepted.
REQ-009 SHALL have port DataOut  output  32  read data for Address, combinational.
REQ-010 SHALL have port serial_in  input  1  RX line, idle high, pre-synchronised upstream.
REQ-011 SHALL have port serial_out  output  1  TX line, idle high.

Function
REQ-012 SHALL use SYMBOL = CLOCK_FREQ/BAUD_RATE (integer, truncated) cycles per bit, with an independent counter per direction.
REQ-013 SHALL drive DataOut: 0x80000000 -> {30'b0, overrun, rx_valid}; 0x80000004 -> {31'b0, tx_ready}; 0x8000000C -> {24'b0, rx_byte}; any other address -> 0.
REQ-014 SHALL implement TX FSM states IDLE, START, DATA, STOP; tx_ready = 1 only in IDLE.
REQ-015 SHALL accept a TX write on the edge where WEUART=1, Address=0x80000008 and state=IDLE: latch DataIn, enter START, tx_ready=0 in the next cycle.
REQ-016 SHALL silently drop a TX write arriving while not in IDLE; the frame in flight is unaffected.
REQ-017 SHALL transmit each frame as a start bit (0), 8 data bits LSB first, and a stop bit (1), each held for exactly SYMBOL cycles; IDLE is re-entered on the cycle after the stop bit ends.
REQ-018 SHALL implement RX FSM states IDLE, START, DATA, STOP; IDLE -> START on serial_in=0.
REQ-019 SHALL resample the start bit at SYMBOL/2; if serial_in=1 there, it SHALL treat the event as a false start and return to IDLE without storing anything.
REQ-020 SHALL sample each data bit and the stop bit at mid-bit, i.e. SYMBOL cycles after the previous sample.
REQ-021 SHALL discard the byte on a stop-bit sample of 0 (framing error) and leave all flags unchanged.
REQ-022 SHALL, on a valid frame with the holding store empty, store the byte and set rx_valid=1 in the next cycle.
REQ-023 SHALL, on a valid frame with the holding store full and no same-cycle pop, keep the stored data, drop the new byte, and set overrun=1.
REQ-024 SHALL pop on the edge where REUART=1 and Address=0x8000000C; popping clears overrun; the data is visible on DataOut in the same cycle as the pop.
REQ-025 SHALL ignore a pop of an empty store: DataOut[7:0]=0, no state change.
REQ-026 SHALL, on a same-edge pop and valid-frame completion, perform the pop before the push: the store ends holding the new byte, rx_valid=1, overrun=0.
REQ-027 SHALL treat WEUART and REUART on non-matching addresses as no-ops.

Reset
REQ-028 SHALL, while reset=1 (asynchronous), force both FSMs to IDLE and set serial_out=1, tx_ready=1, rx_valid=0, overrun=0, rx_byte=0, and both counters to 0.
REQ-029 SHALL abort any frame in progress when reset is asserted mid-frame, with serial_out high immediately and no partial byte stored.
REQ-030 SHALL accept a TX write on the first rising edge after reset deasserts.

Configuration
REQ-031 SHALL, when UART_RX_FIFO_EN is defined, replace the RX holding register with a 4-entry FIFO: rx_valid = not empty; overrun only when a push arrives while full; pop-before-push still applies when full.
REQ-032 SHALL, when UART_RX_FIFO_EN is not defined, use a single-byte holding register as described in REQ-022..026.

Verification (CLOCK_FREQ=50_000_000, BAUD_RATE=115_200, SYMBOL=434)
REQ-033 SHALL cover: write 0x5A to 0x80000008 while idle -> serial_out low 434 cycles, then bits 0,1,0,1,1,0,1,0 at 434 cycles each, stop high; tx_ready=0 for 4340 cycles.
REQ-034 SHALL cover: second write of 0xFF during that frame -> ignored; the line carries only 0x5A; read 0x80000004 returns 0 mid-frame and 1 after the frame.
REQ-035 SHALL cover: drive frame 0xA5 on serial_in -> 0x80000000 reads 1; REUART at 0x8000000C returns 0xA5; status then reads 0.
REQ-036 SHALL cover: send frames 0x11 then 0x22 with no pop -> status reads 3 (0x11 kept, overrun=1); pop returns 0x11 and status reads 0 (no FIFO); with FIFO, reads 0x11 then 0x22.
REQ-037 SHALL cover: 200-cycle low glitch on serial_in -> nothing stored; a frame with stop bit 0 -> nothing stored, flags unchanged.
REQ-038 SHALL cover: assert reset 2000 cycles into a TX frame -> serial_out=1 immediately, tx_ready=1; a new write after release transmits correctly.
